// File: rtl/trigger_sequencer.sv
// rtl/trigger_sequencer.sv - run-control FSM, threshold-crossing trigger and post-trigger window
module trigger_sequencer #(
    parameter int TIME_STAMP_WIDTH = 16,
    parameter int ADC_WIDTH        = 16,
    parameter int ARM_DELAY        = 4,
    parameter int POST_TRG_LEN     = 8
) (
    input  logic                        AXIS_ACLK,
    input  logic                        AXIS_ARESET,
    input  logic                        RUN_EN,
    input  logic [ADC_WIDTH-1:0]        S_ADC_TDATA,
    input  logic                        S_ADC_TVALID,
    input  logic [ADC_WIDTH-1:0]        THRESHOLD_VAL,
    input  logic [TIME_STAMP_WIDTH-1:0] I_CURRENT_TIME,
    output logic [1:0]                  EXEC_STATE,
    output logic [TIME_STAMP_WIDTH-1:0] O_TRG_TIME,
    output logic                        O_TRG_VALID,
    input  logic                        I_TRG_READY,
    output logic [7:0]                  O_MISS_CNT
);

    // Encoding is visible on EXEC_STATE; any non-INIT value keeps the time counter running.
    typedef enum logic [1:0] {
        S_INIT  = 2'b00,
        S_ARMED = 2'b01,
        S_HOLD  = 2'b10,
        S_TRG   = 2'b11
    } state_t;

    localparam int            PW        = $clog2(POST_TRG_LEN + 1);
    localparam logic [7:0]    ARM_MAX   = 8'(ARM_DELAY);
    localparam logic [PW-1:0] POST_MAX  = PW'(POST_TRG_LEN);
    localparam logic [PW-1:0] POST_LAST = PW'(POST_TRG_LEN - 1);

    state_t                      r_state;
    state_t                      w_next;
    logic                        r_prev_above;
    logic [7:0]                  r_arm_cnt;
    logic [PW-1:0]               r_post_cnt;
    logic [TIME_STAMP_WIDTH-1:0] r_trg_time;
    logic                        r_trg_valid;
    logic [7:0]                  r_miss_cnt;

    logic w_above;
    logic w_cross;
    logic w_arm_done;
    logic w_post_done;
    logic w_arm_clr;
    logic w_trig;
    logic w_miss_clr;
    logic w_busy;

    assign w_above     = $signed(S_ADC_TDATA) > $signed(THRESHOLD_VAL);
    assign w_cross     = S_ADC_TVALID && w_above && !r_prev_above;
    assign w_arm_done  = (r_arm_cnt == ARM_MAX);
    assign w_post_done = S_ADC_TVALID && (r_post_cnt == POST_LAST);
    assign w_busy      = (r_state == S_TRG) || (r_state == S_HOLD);
    assign w_miss_clr  = (r_state == S_INIT) && RUN_EN;

    assign EXEC_STATE  = r_state;
    assign O_TRG_TIME  = r_trg_time;
    assign O_TRG_VALID = r_trg_valid;
    assign O_MISS_CNT  = r_miss_cnt;

    // State register.
    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; dropping RUN_EN beats a crossing or window completion in ARMED/TRG.
    always_comb begin
        w_next    = r_state;
        w_arm_clr = 1'b0;
        w_trig    = 1'b0;
        case (r_state)
            S_INIT: begin
                if (RUN_EN) begin
                    w_next    = S_ARMED;
                    w_arm_clr = 1'b1;
                end
            end
            S_ARMED: begin
                if (!RUN_EN) begin
                    w_next = S_INIT;
                end else if (w_cross && w_arm_done) begin
                    w_next = S_TRG;
                    w_trig = 1'b1;
                end
            end
            S_TRG: begin
                if (!RUN_EN) begin
                    w_next = S_INIT;
                end else if (w_post_done) begin
                    w_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (I_TRG_READY) begin
                    if (RUN_EN) begin
                        w_next    = S_ARMED;
                        w_arm_clr = 1'b1;
                    end else begin
                        w_next = S_INIT;
                    end
                end
            end
            default: w_next = S_INIT;
        endcase
    end

    // Previous-sample comparator state; pinned high in INIT so a pre-existing high level cannot trigger.
    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            r_prev_above <= 1'b1;
        end else if (r_state == S_INIT) begin
            r_prev_above <= 1'b1;
        end else if (S_ADC_TVALID) begin
            r_prev_above <= w_above;
        end
    end

    // Arm-delay counter: restarts on every entry to ARMED and saturates at the delay.
    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            r_arm_cnt <= '0;
        end else if (w_arm_clr) begin
            r_arm_cnt <= '0;
        end else if ((r_state == S_ARMED) && !w_arm_done) begin
            r_arm_cnt <= r_arm_cnt + 8'd1;
        end
    end

    // Post-trigger sample counter: cleared by the trigger, counts valid samples in TRG, never wraps.
    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            r_post_cnt <= '0;
        end else if (w_trig) begin
            r_post_cnt <= '0;
        end else if ((r_state == S_TRG) && S_ADC_TVALID && (r_post_cnt != POST_MAX)) begin
            r_post_cnt <= r_post_cnt + 1'b1;
        end
    end

    // Trigger record: timestamp captured on the crossing edge, valid tracks residence in HOLD.
    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            r_trg_time  <= '0;
            r_trg_valid <= 1'b0;
        end else begin
            if (w_trig) begin
                r_trg_time <= I_CURRENT_TIME;
            end
            r_trg_valid <= (w_next == S_HOLD);
        end
    end

    // Saturating count of crossings that arrive while a trigger is already in flight.
    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            r_miss_cnt <= '0;
        end else if (w_miss_clr) begin
            r_miss_cnt <= '0;
        end else if (w_busy && w_cross && (r_miss_cnt != 8'hFF)) begin
            r_miss_cnt <= r_miss_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_trigger_sequencer.sv
// tb/tb_trigger_sequencer.sv - scoreboard bench for trigger_sequencer
module tb_trigger_sequencer;

    logic        clk;
    logic        rst;
    logic        run_en;
    logic [15:0] tdata;
    logic        tvalid;
    logic [15:0] thresh;
    logic [15:0] cur_time;
    logic [1:0]  exec_state;
    logic [15:0] trg_time;
    logic        trg_valid;
    logic        trg_ready;
    logic [7:0]  miss_cnt;

    typedef struct packed {
        logic [15:0] t;
        logic [7:0]  m;
    } rec_t;

    rec_t exp_q[$];
    int   n_checks;
    int   n_errors;

    trigger_sequencer #(
        .TIME_STAMP_WIDTH(16),
        .ADC_WIDTH(16),
        .ARM_DELAY(4),
        .POST_TRG_LEN(8)
    ) dut (
        .AXIS_ACLK(clk),
        .AXIS_ARESET(rst),
        .RUN_EN(run_en),
        .S_ADC_TDATA(tdata),
        .S_ADC_TVALID(tvalid),
        .THRESHOLD_VAL(thresh),
        .I_CURRENT_TIME(cur_time),
        .EXEC_STATE(exec_state),
        .O_TRG_TIME(trg_time),
        .O_TRG_VALID(trg_valid),
        .I_TRG_READY(trg_ready),
        .O_MISS_CNT(miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_samples(input int n, input logic [15:0] v);
        for (int i = 0; i < n; i++) begin
            tdata  = v;
            tvalid = 1'b1;
            tick();
        end
    endtask

    // Monitor: a record leaves on the next edge whenever VALID and READY are both high mid-cycle.
    always @(negedge clk) begin
        if (!rst && trg_valid === 1'b1 && trg_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_record: got time 0x%0h with no record expected", trg_time);
            end else begin
                rec_t r;
                r = exp_q.pop_front();
                check("record_time", {16'd0, trg_time}, {16'd0, r.t});
                check("record_miss", {24'd0, miss_cnt}, {24'd0, r.m});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        run_en    = 1'b0;
        tdata     = 16'd0;
        tvalid    = 1'b0;
        thresh    = 16'd100;
        cur_time  = 16'd0;
        trg_ready = 1'b1;
        #2;
        check("reset_state", {30'd0, exec_state}, 32'd0);
        check("reset_time", {16'd0, trg_time}, 32'd0);
        check("reset_valid", {31'd0, trg_valid}, 32'd0);
        check("reset_miss", {24'd0, miss_cnt}, 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // Basic trigger
        tdata = 16'd0; tvalid = 1'b1; run_en = 1'b1;
        tick();
        check("arm_latency", {30'd0, exec_state}, 32'd1);
        run_samples(8, 16'd0);
        check("armed_idle", {30'd0, exec_state}, 32'd1);
        cur_time = 16'h0042;
        exp_q.push_back('{t: 16'h0042, m: 8'd0});
        run_samples(1, 16'd200);
        check("basic_trg_state", {30'd0, exec_state}, 32'd3);
        check("basic_trg_time", {16'd0, trg_time}, 32'h42);
        cur_time = 16'h0099;
        run_samples(7, 16'd200);
        check("basic_post7_state", {30'd0, exec_state}, 32'd3);
        check("basic_post7_valid", {31'd0, trg_valid}, 32'd0);
        run_samples(1, 16'd200);
        check("basic_hold_state", {30'd0, exec_state}, 32'd2);
        check("basic_hold_valid", {31'd0, trg_valid}, 32'd1);
        tick();
        check("basic_rearm_state", {30'd0, exec_state}, 32'd1);
        check("basic_rearm_valid", {31'd0, trg_valid}, 32'd0);

        // Pre-armed level and early crossing
        run_en = 1'b0;
        tick();
        check("disarm_state", {30'd0, exec_state}, 32'd0);
        run_en = 1'b1;
        run_samples(1, 16'd200);
        run_samples(8, 16'd200);
        check("prearmed_no_trig", {30'd0, exec_state}, 32'd1);
        run_en = 1'b0;
        tick();
        run_en = 1'b1;
        run_samples(1, 16'd200);
        run_samples(1, 16'd0);
        run_samples(1, 16'd200);
        check("early_cross_ignored", {30'd0, exec_state}, 32'd1);
        run_samples(3, 16'd0);
        check("cycle5_armed", {30'd0, exec_state}, 32'd1);
        cur_time  = 16'h1234;
        trg_ready = 1'b0;
        exp_q.push_back('{t: 16'h1234, m: 8'd3});
        run_samples(1, 16'd200);
        check("cycle6_trg", {30'd0, exec_state}, 32'd3);

        // Backpressure with busy crossings
        run_samples(8, 16'd0);
        check("bp_hold_state", {30'd0, exec_state}, 32'd2);
        for (int i = 0; i < 20; i++) begin
            cur_time = 16'(i);
            run_samples(1, (i < 6 && (i % 2) == 0) ? 16'd200 : 16'd0);
        end
        check("bp_state", {30'd0, exec_state}, 32'd2);
        check("bp_valid", {31'd0, trg_valid}, 32'd1);
        check("bp_time_stable", {16'd0, trg_time}, 32'h1234);
        check("bp_miss", {24'd0, miss_cnt}, 32'd3);
        trg_ready = 1'b1;
        run_samples(1, 16'd0);
        check("bp_release_state", {30'd0, exec_state}, 32'd1);
        check("bp_release_valid", {31'd0, trg_valid}, 32'd0);

        // Abort in TRG
        run_samples(5, 16'd0);
        cur_time = 16'h0777;
        run_samples(1, 16'd200);
        check("abort_trg_state", {30'd0, exec_state}, 32'd3);
        run_samples(3, 16'd0);
        run_en = 1'b0;
        run_samples(1, 16'd0);
        check("abort_trg_init", {30'd0, exec_state}, 32'd0);
        check("abort_trg_valid", {31'd0, trg_valid}, 32'd0);
        check("abort_trg_time_kept", {16'd0, trg_time}, 32'h0777);

        // Abort in HOLD
        run_en = 1'b1;
        run_samples(1, 16'd0);
        run_samples(5, 16'd0);
        cur_time  = 16'h0ABC;
        trg_ready = 1'b0;
        exp_q.push_back('{t: 16'h0ABC, m: 8'd0});
        run_samples(1, 16'd200);
        run_samples(8, 16'd0);
        check("abort_hold_state", {30'd0, exec_state}, 32'd2);
        run_en = 1'b0;
        run_samples(2, 16'd0);
        check("hold_ignores_run_en", {30'd0, exec_state}, 32'd2);
        trg_ready = 1'b1;
        run_samples(1, 16'd0);
        check("abort_hold_init", {30'd0, exec_state}, 32'd0);
        check("abort_hold_valid", {31'd0, trg_valid}, 32'd0);

        // Miss saturation
        run_en = 1'b1;
        run_samples(1, 16'd0);
        run_samples(5, 16'd0);
        cur_time  = 16'h0F0F;
        trg_ready = 1'b0;
        exp_q.push_back('{t: 16'h0F0F, m: 8'd255});
        run_samples(1, 16'd200);
        run_samples(8, 16'd0);
        for (int i = 0; i < 300; i++) begin
            run_samples(1, 16'd200);
            run_samples(1, 16'd0);
        end
        check("sat_state", {30'd0, exec_state}, 32'd2);
        check("sat_miss", {24'd0, miss_cnt}, 32'd255);
        run_en    = 1'b0;
        trg_ready = 1'b1;
        run_samples(1, 16'd0);
        check("sat_init_state", {30'd0, exec_state}, 32'd0);
        check("sat_miss_kept", {24'd0, miss_cnt}, 32'd255);
        run_en = 1'b1;
        run_samples(1, 16'd0);
        check("rearm_miss_clear", {24'd0, miss_cnt}, 32'd0);

        // Async reset mid-TRG
        run_samples(5, 16'd0);
        cur_time = 16'h5555;
        run_samples(1, 16'd200);
        check("rst_pre_state", {30'd0, exec_state}, 32'd3);
        run_samples(1, 16'd0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_state", {30'd0, exec_state}, 32'd0);
        check("async_rst_time", {16'd0, trg_time}, 32'd0);
        check("async_rst_valid", {31'd0, trg_valid}, 32'd0);
        check("async_rst_miss", {24'd0, miss_cnt}, 32'd0);
        tick();
        run_en = 1'b0;
        rst    = 1'b0;
        tick();
        check("queue_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/trigger_sequencer.md
# trigger_sequencer

Run-control and trigger sequencer that drives the 2-bit `EXEC_STATE` bus consumed by the time counter and the downstream capture logic. It arms on a run-enable command and detects a rising threshold crossing on the ADC AXI-Stream sample stream. On a crossing it latches the current timestamp, counts a fixed post-trigger window, and then hands the trigger record downstream over a valid/ready handshake. It sits between the ADC input stage and the time counter/event packer, and is the sole owner of `EXEC_STATE`.

## Interface
- `TIME_STAMP_WIDTH`, 16, width of the timestamp input and of the latched timestamp.
- `ADC_WIDTH`, 16, width of the ADC sample; two's-complement signed.
- `ARM_DELAY`, 4, clock cycles spent in ARMED before comparisons are enabled (range 1..255).
- `POST_TRG_LEN`, 8, number of valid samples counted in TRG after the trigger sample (range ≥1).

Ports. One clock; reset is asynchronous and active-high.
- `AXIS_ACLK`  in  1  clock.
- `AXIS_ARESET`  in  1  asynchronous active-high reset.
- `RUN_EN`  in  1  level; high requests acquisition.
- `S_ADC_TDATA`  in  ADC_WIDTH  signed sample.
- `S_ADC_TVALID`  in  1  sample qualifier (no backpressure; no TREADY).
- `THRESHOLD_VAL`  in  ADC_WIDTH  signed threshold; static while ARMED.
- `I_CURRENT_TIME`  in  TIME_STAMP_WIDTH  time counter output.
- `EXEC_STATE`  out  2  INIT=00, ARMED=01, HOLD=10, TRG=11.
- `O_TRG_TIME`  out  TIME_STAMP_WIDTH  timestamp latched at trigger.
- `O_TRG_VALID`  out  1  trigger record valid.
- `I_TRG_READY`  in  1  downstream accepts the record.
- `O_MISS_CNT`  out  8  saturating count of crossings lost while busy.

## Operation
- Sample compare: `above = (signed S_ADC_TDATA > signed THRESHOLD_VAL)`, evaluated only when `S_ADC_TVALID`=1. The `prev_above` register updates on every valid sample in every state except INIT. In INIT it is held at 1, so a level that is already above threshold at arm time does not trigger.
- Crossing: `S_ADC_TVALID && above && !prev_above`.
- INIT: `RUN_EN`=1 → ARMED. On this transition: arm counter cleared, `O_MISS_CNT` cleared.
- ARMED: the arm counter increments each cycle up to `ARM_DELAY`, then holds.
  - A crossing with arm counter == `ARM_DELAY` → TRG. On the same edge: `O_TRG_TIME <= I_CURRENT_TIME`, post counter cleared.
  - Crossings before the delay expires are ignored and not counted as misses.
- TRG: the post counter increments on each valid sample. When the `POST_TRG_LEN`-th valid sample arrives → HOLD.
- HOLD: `O_TRG_VALID`=1 and `O_TRG_TIME` is stable. On `O_TRG_VALID && I_TRG_READY`:
  - → ARMED with arm counter cleared if `RUN_EN`=1 (the arm delay re-applies);
  - otherwise → INIT.
- Busy crossings: any crossing in TRG or HOLD increments `O_MISS_CNT`, saturating at 255.
- `RUN_EN` deassert:
  - in ARMED or TRG → INIT on the next edge; the pending trigger is discarded and `O_TRG_TIME` is retained;
  - in HOLD → no effect until the handshake completes, then INIT.
- Priority in ARMED and TRG: `RUN_EN`=0 wins over a crossing or post-window completion on the same cycle.
- Encoding HOLD=10 keeps the time counter running (any non-INIT state enables it).
- Counter widths: arm counter 8 bits; post counter `$clog2(POST_TRG_LEN+1)` bits, no wrap.

## Timing
- Reset (async assert, release synchronous to `AXIS_ACLK`) sets the following:
  - `EXEC_STATE`=00, `O_TRG_TIME`=0, `O_TRG_VALID`=0, `O_MISS_CNT`=0;
  - `prev_above`=1, arm counter and post counter = 0.
- All outputs are registered; no combinational path from any input to any output.
- Latency, `RUN_EN` rise → `EXEC_STATE`=01: 1 cycle.
- Arm delay: comparisons are enabled from cycle `ARM_DELAY`+1 after entering ARMED.
- Crossing sample edge: `EXEC_STATE`=11 and `O_TRG_TIME` updated on that same edge. The captured value is `I_CURRENT_TIME` as sampled on that edge.
- Edge accepting the `POST_TRG_LEN`-th post sample: `EXEC_STATE`=10 and `O_TRG_VALID`=1 on that same edge.
- Handshake: the transfer occurs on an edge with VALID&&READY; on the next cycle `O_TRG_VALID`=0 and the state is ARMED/INIT. READY may be high before VALID, so the minimum HOLD dwell is 1 cycle.
- Reset mid-operation: immediate return to reset values; a record in HOLD is lost.

## Test plan
- Basic trigger: `ARM_DELAY`=4, `POST_TRG_LEN`=8, threshold 100. `RUN_EN`=1, continuous samples 0 then 200 at cycle 10, `I_CURRENT_TIME`=0x0042 on that edge, READY=1 → `EXEC_STATE` 00→01→11 at the crossing edge, 10 after 8 more samples, `O_TRG_TIME`=0x0042, VALID high for 1 cycle, then 01.
- Arm-delay / pre-armed level: samples already 200 at arm → no trigger. A drop to 0 and rise to 200 at ARMED cycle 2 → no trigger. Rise at ARMED cycle 6 → TRG.
- Backpressure: hold READY=0 for 20 cycles in HOLD with 3 crossings → `O_TRG_TIME` stable, VALID held, `O_MISS_CNT`=3; READY=1 → ARMED next cycle.
- Abort: `RUN_EN`=0 in TRG after 3 post samples → 00 next edge, VALID never asserted. `RUN_EN`=0 in HOLD → record still transferred on READY, then 00.
- Miss saturation: 300 crossings while HOLD is stalled → `O_MISS_CNT`=255. Re-arm from INIT → 0.
- Async reset asserted mid-TRG between clock edges → all outputs return to reset values immediately, without waiting for a clock edge.
